// File: rtl/hex_scan_display.sv
// Eight-digit multiplexed hex display driver for the core's ALU result bus.
// A captured 32-bit value is scanned one nibble per slot onto an active-low
// common-anode display, with optional leading-zero blanking and a freeze
// indicator on the decimal point of digit 0.
module hex_scan_display #(
    parameter int unsigned DIV      = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dato_i,
    input  logic        cargar_i,
    input  logic        congelar_i,
    output logic [6:0]  seg_o,
    output logic [7:0]  an_o,
    output logic        dp_o
);

    // Prescaler terminal count; 20 bits covers the full 1..2^20 range of DIV.
    localparam logic [19:0] LAST = 20'(DIV - 1);

    logic [31:0] valor_q, valor_d;
    logic [19:0] presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic        tick;

    logic [6:0]  seg_q, seg_d;
    logic [7:0]  an_q, an_d;
    logic        dp_q, dp_d;

    logic [31:0] upper;

    // Capture, prescaler and digit-index next state.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        valor_d = valor_q;
        if (cargar_i && !congelar_i) begin
            valor_d = dato_i;
        end
        tick    = (presc_q == LAST);
        presc_d = tick ? 20'd0 : presc_q + 20'd1;
        idx_d   = tick ? idx_q + 3'd1 : idx_q;
    end

    // Decode the current slot: anode select, hex pattern, blanking, freeze dot.
    always_comb begin
        // Nibbles idx..7 moved down to the bottom; zero means a leading zero.
        upper = valor_q >> {idx_q, 2'b00};
        seg_d = 7'b1111111;
        case (upper[3:0])
            4'h0: seg_d = 7'b1000000;
            4'h1: seg_d = 7'b1111001;
            4'h2: seg_d = 7'b0100100;
            4'h3: seg_d = 7'b0110000;
            4'h4: seg_d = 7'b0011001;
            4'h5: seg_d = 7'b0010010;
            4'h6: seg_d = 7'b0000010;
            4'h7: seg_d = 7'b1111000;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0010000;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b0000011;
            4'hC: seg_d = 7'b1000110;
            4'hD: seg_d = 7'b0100001;
            4'hE: seg_d = 7'b0000110;
            4'hF: seg_d = 7'b0001110;
            default: seg_d = 7'b1111111;
        endcase
        // Digit 0 always shows, so a zero value still displays a single 0.
        if (BLANK_LZ && (idx_q != 3'd0) && (upper == 32'd0)) begin
            seg_d = 7'b1111111;
        end
        an_d = ~(8'd1 << idx_q);
        dp_d = !((idx_q == 3'd0) && congelar_i);
    end

    // State and registered display outputs; reset shows a lone 0 on digit 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valor_q <= 32'd0;
            presc_q <= 20'd0;
            idx_q   <= 3'd0;
            seg_q   <= 7'b1000000;
            an_q    <= 8'b11111110;
            dp_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            valor_q <= valor_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;
    assign dp_o  = dp_q;

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving clock cycles per digit slot (legal range 1..2^20).
REQ-002 The block SHALL have parameter BLANK_LZ, default 1, where 1 enables leading-zero blanking.
REQ-003 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 dato_i  input  32  value produced by the single-cycle core (its ALU result monitor bus).
REQ-006 cargar_i  input  1  capture strobe; samples dato_i.
REQ-007 congelar_i  input  1  freeze; blocks capture while high.
REQ-008 seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 an_o  output  8  digit enables, active-low, bit n = digit n (digit 0 = least significant nibble).
REQ-010 dp_o  output  1  decimal point, active-low.

Function
REQ-011 Capture register valor_r SHALL load dato_i on a rising edge where cargar_i=1 and congelar_i=0; otherwise it holds.
REQ-012 Prescaler SHALL count 0..DIV-1, wrap to 0, and assert an internal tick in the cycle it equals DIV-1; DIV=1 ticks every cycle.
REQ-013 Digit index idx (3 bits) SHALL advance by 1 on each tick, wrapping 7 -> 0.
REQ-014 Outputs SHALL be registered: seg_o, an_o, dp_o at edge k reflect idx, valor_r, congelar_i sampled at edge k-1 (one-cycle latency).
REQ-015 an_o SHALL drive exactly bit idx low and all other bits high, including for blanked digits.
REQ-016 seg_o SHALL show nibble valor_r[4*idx+3 : 4*idx] by hex decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 With BLANK_LZ=1, digit idx>0 SHALL be blanked (seg_o=1111111) when nibbles idx..7 of valor_r are all zero; digit 0 SHALL never be blanked.
REQ-018 With BLANK_LZ=0, no digit SHALL be blanked.
REQ-019 dp_o SHALL be 0 only when idx=0 and congelar_i=1, else 1.
REQ-020 cargar_i and tick in the same cycle SHALL both take effect; the new valor_r is used from the following output update.
REQ-021 Changing congelar_i from 1 to 0 SHALL NOT by itself load valor_r; a cargar_i pulse is required.
REQ-022 No handshake back to the core SHALL exist; the block SHALL never stall the core.

Reset
REQ-023 On rst_ni=0, immediately and independent of clk_i: valor_r=0, prescaler=0, idx=0, an_o=11111110, seg_o=1000000, dp_o=1.
REQ-024 Reset asserted mid-scan SHALL abort the current slot; after release the first tick SHALL occur DIV cycles after the first rising edge.
REQ-025 Capture SHALL be inhibited while rst_ni=0.

Verification
REQ-026 Reset, DIV=4, no capture -> an_o cycles FE,FD,...,7F every 4 cycles; seg_o=1000000 on digit 0, 1111111 on digits 1..7.
REQ-027 DIV=2, cargar_i pulse with dato_i=32'h1234ABCD -> digits 0..7 show d,C,b,A,4,3,2,1 (0100001,1000110,0000011,0001000,0011001,0110000,0100100,1111001).
REQ-028 congelar_i=1, cargar_i pulse with dato_i=32'hFFFFFFFF -> valor_r unchanged, dp_o=0 only while an_o=FE.
REQ-029 BLANK_LZ=0, valor_r=32'h00000050 -> digits 2..7 show 1000000; BLANK_LZ=1 -> digits 2..7 show 1111111, digit 1 shows 0010010.
REQ-030 DIV=1, cargar_i asserted coincident with tick, dato_i=32'h8 -> next output update shows 0000000 on digit 0; mid-scan rst_ni pulse -> outputs snap to reset values without a clock edge.
